// File: rtl/adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings and a
// ceil-log2 helper used to size the bit counter.
package adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ceil(log2(value)), never less than 1 so a counter always has one bit
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_add_sequencer_fa.sv
// One-bit full-adder cell, shared by every bit position of the serial add.
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic S,
  output logic C_out
);

  // purely combinational sum and carry
  assign S     = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: one full-adder cell adds A+B+C_in one bit per
// clock, LSB first. Handshake: start is accepted only in IDLE or DONE (a start
// seen while busy is dropped); busy is high for the WIDTH RUN cycles; done is a
// one-cycle pulse in the DONE state, from which sum/c_out are valid and held.
module serial_add_sequencer
  import adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // FSM state kept in a single named register so checkers can bind to it
  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] s_next;

  FullAdder u_fa (
    .A     (a_sh[0]),
    .B     (b_sh[0]),
    .C_in  (carry),
    .S     (fa_s),
    .C_out (fa_co)
  );

  // new sum bit enters at the MSB so after WIDTH shifts bit 0 is the first sum bit
  assign s_next = {fa_s, s_sh[WIDTH-1:1]};

  // status outputs decode directly from the state register
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // FSM, shift registers, carry feedback, bit counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            count <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_next;
          carry <= fa_co;
          if (count == LAST_BIT) begin
            // last bit: publish the complete result, never a partial one
            sum   <= s_next;
            c_out <= fa_co;
            state <= ST_DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer at WIDTH=4 with a 10 ns clock.
module tb_serial_add_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic       busy;
  logic       done;
  logic [3:0] sum;
  logic       c_out;

  int checks;
  int errors;

  serial_add_sequencer #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle and settle 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic eb, input logic ed,
                         input logic [3:0] es, input logic ec);
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".sum"}, 32'(sum), 32'(es));
    chk({tag, ".c_out"}, 32'(c_out), 32'(ec));
  endtask

  // one complete add: start pulse, WIDTH busy cycles with held outputs, done, idle
  task automatic run_add(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                         input logic tc, input logic [3:0] old_s, input logic old_c,
                         input logic [3:0] es, input logic ec);
    a = ta; b = tb; c_in = tc; start = 1'b1;
    tick();
    start = 1'b0; a = 4'h0; b = 4'h0; c_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out({tag, ".run"}, 1'b1, 1'b0, old_s, old_c);
      tick();
    end
    chk_out({tag, ".done"}, 1'b0, 1'b1, es, ec);
    tick();
    chk_out({tag, ".idle"}, 1'b0, 1'b0, es, ec);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; a = 4'h0; b = 4'h0; c_in = 1'b0;

    // 1. reset
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_out("reset", 1'b0, 1'b0, 4'h0, 1'b0);

    // 2. basic add and latency
    run_add("add_3_5", 4'h3, 4'h5, 1'b0, 4'h0, 1'b0, 4'h8, 1'b0);

    // 3. wrap and full carry chain
    run_add("add_f_1", 4'hF, 4'h1, 1'b0, 4'h8, 1'b0, 4'h0, 1'b1);
    run_add("add_f_f_c", 4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 4'hF, 1'b1);
    run_add("add_a_5_c", 4'hA, 4'h5, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1);

    // 4. start while busy is dropped
    a = 4'h2; b = 4'h2; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("busy_drop.b1", 1'b1, 1'b0, 4'h0, 1'b1);
    tick();
    a = 4'h7; b = 4'h7; start = 1'b1;
    chk_out("busy_drop.b2", 1'b1, 1'b0, 4'h0, 1'b1);
    tick();
    start = 1'b0;
    chk_out("busy_drop.b3", 1'b1, 1'b0, 4'h0, 1'b1);
    tick();
    chk_out("busy_drop.b4", 1'b1, 1'b0, 4'h0, 1'b1);
    tick();
    chk_out("busy_drop.done", 1'b0, 1'b1, 4'h4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("busy_drop.quiet", 1'b0, 1'b0, 4'h4, 1'b0);
    end

    // 5. reset mid-run aborts
    a = 4'h6; b = 4'h3; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("abort.b1", 1'b1, 1'b0, 4'h4, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("abort.reset", 1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("abort.quiet", 1'b0, 1'b0, 4'h0, 1'b0);
    end

    // 6. back-to-back: start held through the DONE cycle
    a = 4'h1; b = 4'h1; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out("b2b.run1", 1'b1, 1'b0, 4'h0, 1'b0);
      tick();
    end
    chk_out("b2b.done1", 1'b0, 1'b1, 4'h2, 1'b0);
    a = 4'h9; b = 4'h9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out("b2b.run2", 1'b1, 1'b0, 4'h2, 1'b0);
      tick();
    end
    chk_out("b2b.done2", 1'b0, 1'b1, 4'h2, 1'b1);
    tick();
    chk_out("b2b.idle", 1'b0, 1'b0, 4'h2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
